// File: rtl/ssd_pkg.sv
// ssd_pkg -- shared constants for the seven-segment scan decoder.
//
// Holds the 5-bit symbol codes and the 8-bit active-low cathode patterns.
// The pattern table is the one the display encoder drives, so encoder and
// decoder stay bit-identical. Cathode bit order: bit0=a ... bit6=g, bit7=dp.
// Every pattern here has dp off (bit7 = 1).
package ssd_pkg;

  typedef logic [4:0] sym_code_t;

  // Symbol codes
  localparam sym_code_t SYM_0       = 5'd0;
  localparam sym_code_t SYM_1       = 5'd1;
  localparam sym_code_t SYM_2       = 5'd2;
  localparam sym_code_t SYM_3       = 5'd3;
  localparam sym_code_t SYM_4       = 5'd4;
  localparam sym_code_t SYM_5       = 5'd5;
  localparam sym_code_t SYM_6       = 5'd6;
  localparam sym_code_t SYM_7       = 5'd7;
  localparam sym_code_t SYM_8       = 5'd8;
  localparam sym_code_t SYM_9       = 5'd9;
  localparam sym_code_t SYM_F       = 5'd21;
  localparam sym_code_t SYM_A       = 5'd22;
  localparam sym_code_t SYM_I       = 5'd23;
  localparam sym_code_t SYM_L       = 5'd24;
  localparam sym_code_t SYM_E       = 5'd27;
  localparam sym_code_t SYM_LOWER_D = 5'd28;
  localparam sym_code_t SYM_BLANK   = 5'd30;
  localparam sym_code_t SYM_UNKNOWN = 5'd31;

  // Active-low cathode patterns
  localparam logic [7:0] PAT_0       = 8'hC0;
  localparam logic [7:0] PAT_1       = 8'hF9;
  localparam logic [7:0] PAT_2       = 8'hA4;
  localparam logic [7:0] PAT_3       = 8'hB0;
  localparam logic [7:0] PAT_4       = 8'h99;
  localparam logic [7:0] PAT_5       = 8'h92;
  localparam logic [7:0] PAT_6       = 8'h82;
  localparam logic [7:0] PAT_7       = 8'hF8;
  localparam logic [7:0] PAT_8       = 8'h80;
  localparam logic [7:0] PAT_9       = 8'h90;
  localparam logic [7:0] PAT_F       = 8'h8E;
  localparam logic [7:0] PAT_A       = 8'h88;
  localparam logic [7:0] PAT_I       = 8'hCF;
  localparam logic [7:0] PAT_L       = 8'hC7;
  localparam logic [7:0] PAT_E       = 8'h86;
  localparam logic [7:0] PAT_LOWER_D = 8'hA1;
  localparam logic [7:0] PAT_BLANK   = 8'hFF;

endpackage

// File: rtl/ssd_pattern_decode.sv
// ssd_pattern_decode -- combinational segment-pattern to symbol-code lookup.
//
// Ports:
//   seg_i      [6:0]  active-low segments g..a (dp excluded)
//   code_o     [4:0]  symbol code, SYM_UNKNOWN when the pattern is not in the table
//   unknown_o         high when the pattern is not in the table
module ssd_pattern_decode
  import ssd_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [4:0] code_o,
  output logic       unknown_o
);

  // Table lookup against the shared encoder patterns, dp bit stripped
  always_comb begin
    code_o    = SYM_UNKNOWN;
    unknown_o = 1'b0;
    case (seg_i)
      PAT_0[6:0]:       code_o = SYM_0;
      PAT_1[6:0]:       code_o = SYM_1;
      PAT_2[6:0]:       code_o = SYM_2;
      PAT_3[6:0]:       code_o = SYM_3;
      PAT_4[6:0]:       code_o = SYM_4;
      PAT_5[6:0]:       code_o = SYM_5;
      PAT_6[6:0]:       code_o = SYM_6;
      PAT_7[6:0]:       code_o = SYM_7;
      PAT_8[6:0]:       code_o = SYM_8;
      PAT_9[6:0]:       code_o = SYM_9;
      PAT_F[6:0]:       code_o = SYM_F;
      PAT_A[6:0]:       code_o = SYM_A;
      PAT_I[6:0]:       code_o = SYM_I;
      PAT_L[6:0]:       code_o = SYM_L;
      PAT_E[6:0]:       code_o = SYM_E;
      PAT_LOWER_D[6:0]: code_o = SYM_LOWER_D;
      PAT_BLANK[6:0]:   code_o = SYM_BLANK;
      default: begin
        code_o    = SYM_UNKNOWN;
        unknown_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ssd_scan_decoder.sv
// ssd_scan_decoder -- recovers the four displayed symbols by snooping the
// anode/cathode lines of a multiplexed seven-segment display.
//
// Optional feature macro: SSD_DP_CAPTURE_EN (capture decimal points and use
// cathode bit7 in change detection). Without it bit7 is ignored and dp is 0.
//
// Ports:
//   clk                 rising-edge clock
//   reset               asynchronous, active-low reset
//   ssdAnode    [7:0]   digit selects, active-low ([3:0] scanned, [7:4] idle high)
//   ssdCathode  [7:0]   segments, active-low (bit0=a .. bit6=g, bit7=dp)
//   digits      [19:0]  four 5-bit symbol codes, digit n at [5n+4:5n]
//   dp          [3:0]   captured decimal points, active-high
//   frame_valid         one-cycle pulse when digits/dp update
//   sym_err             one-cycle pulse for a captured unknown pattern
//   anode_err           pulse for each cycle with an illegal (non-blank) select
//   timeout             level, no capture for TIMEOUT_CYCLES cycles
module ssd_scan_decoder
  import ssd_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  ssdAnode,
  input  logic [7:0]  ssdCathode,
  output logic [19:0] digits,
  output logic [3:0]  dp,
  output logic        frame_valid,
  output logic        sym_err,
  output logic        anode_err,
  output logic        timeout
);

  localparam logic [7:0]  STABLE_C  = 8'(STABLE_CYCLES);
  localparam logic [19:0] TIMEOUT_C = 20'(TIMEOUT_CYCLES);

`ifdef SSD_DP_CAPTURE_EN
  localparam int KEY_W = 8;
`else
  localparam int KEY_W = 7;
  logic unusedCatDp;
  assign unusedCatDp = ssdCathode[7];
`endif

  logic [7:0]       anMeta_q, anSync_q, anPrev_q;
  logic [KEY_W-1:0] catMeta_q, catSync_q, catPrev_q;
  logic [7:0]       dwell_q, dwell_d;
  logic [3:0]       mask_q, mask_d, maskAfterCap;
  logic [19:0]      tmo_q, tmo_d;
  logic [3:0][4:0]  shadow_q, shadowNext;
  logic [19:0]      digits_q;
  logic             frameValid_q, symErr_q, anodeErr_q;
  logic [1:0]       selIdx;
  logic             selOneLow, legal, changed, capture, publish, anodeBad;
  logic [4:0]       code;
  logic             unknown;

  // Two-flop synchronizers; idle (all ones) is the safe reset value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      anMeta_q  <= '1;
      anSync_q  <= '1;
      catMeta_q <= '1;
      catSync_q <= '1;
    end else begin
      anMeta_q  <= ssdAnode;
      anSync_q  <= anMeta_q;
      catMeta_q <= ssdCathode[KEY_W-1:0];
      catSync_q <= catMeta_q;
    end
  end

  // Which digit is selected, and whether exactly one of [3:0] is low
  always_comb begin
    selIdx    = 2'd0;
    selOneLow = 1'b1;
    case (anSync_q[3:0])
      4'b1110: selIdx = 2'd0;
      4'b1101: selIdx = 2'd1;
      4'b1011: selIdx = 2'd2;
      4'b0111: selIdx = 2'd3;
      default: selOneLow = 1'b0;
    endcase
  end

  assign legal    = selOneLow && (anSync_q[7:4] == 4'hF);
  // All-high is inter-digit blanking, not a fault
  assign anodeBad = !legal && (anSync_q != 8'hFF);
  assign changed  = (anSync_q != anPrev_q) || (catSync_q != catPrev_q);

  ssd_pattern_decode u_decode (
    .seg_i     (catSync_q[6:0]),
    .code_o    (code),
    .unknown_o (unknown)
  );

  // Dwell counter; a zero count also restarts so a dwell after an illegal
  // select always begins at 1. Capture needs the count to arrive at
  // STABLE_CYCLES, so a saturated dwell never fires again.
  always_comb begin
    dwell_d = dwell_q;
    if (!legal)
      dwell_d = 8'd0;
    else if (changed || dwell_q == 8'd0)
      dwell_d = 8'd1;
    else if (dwell_q != 8'hFF)
      dwell_d = dwell_q + 8'd1;
  end

  assign capture = legal && (dwell_d == STABLE_C) && (dwell_q != STABLE_C);

  // Mask update; completing the mask publishes and clears it in one step
  always_comb begin
    maskAfterCap = mask_q;
    if (capture)
      maskAfterCap[selIdx] = 1'b1;
  end

  assign publish = capture && (maskAfterCap == 4'hF);
  assign mask_d  = publish ? 4'h0 : maskAfterCap;

  always_comb begin
    shadowNext = shadow_q;
    if (capture)
      shadowNext[selIdx] = code;
  end

  always_comb begin
    tmo_d = tmo_q;
    if (capture)
      tmo_d = 20'd0;
    else if (tmo_q != TIMEOUT_C)
      tmo_d = tmo_q + 20'd1;
  end

  // Control state: previous sample, dwell, mask and timeout counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      anPrev_q  <= '1;
      catPrev_q <= '1;
      dwell_q   <= 8'd0;
      mask_q    <= 4'h0;
      tmo_q     <= 20'd0;
    end else begin
      anPrev_q  <= anSync_q;
      catPrev_q <= catSync_q;
      dwell_q   <= dwell_d;
      mask_q    <= mask_d;
      tmo_q     <= tmo_d;
    end
  end

  // Shadow slots and published digits; publishing uses the post-capture
  // shadow so the output appears one cycle after the completing capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow_q <= {4{SYM_BLANK}};
      digits_q <= {4{SYM_BLANK}};
    end else begin
      shadow_q <= shadowNext;
      if (publish)
        digits_q <= shadowNext;
    end
  end

  // Registered status pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frameValid_q <= 1'b0;
      symErr_q     <= 1'b0;
      anodeErr_q   <= 1'b0;
    end else begin
      frameValid_q <= publish;
      symErr_q     <= capture && unknown;
      anodeErr_q   <= anodeBad;
    end
  end

`ifdef SSD_DP_CAPTURE_EN
  logic [3:0] dpShadow_q, dpShadowNext, dp_q;

  always_comb begin
    dpShadowNext = dpShadow_q;
    if (capture)
      dpShadowNext[selIdx] = ~catSync_q[7];
  end

  // Decimal points travel with their digit through shadow and publish
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dpShadow_q <= 4'h0;
      dp_q       <= 4'h0;
    end else begin
      dpShadow_q <= dpShadowNext;
      if (publish)
        dp_q <= dpShadowNext;
    end
  end

  assign dp = dp_q;
`else
  assign dp = 4'h0;
`endif

  assign digits      = digits_q;
  assign frame_valid = frameValid_q;
  assign sym_err     = symErr_q;
  assign anode_err   = anodeErr_q;
  assign timeout     = (tmo_q == TIMEOUT_C);

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// tb_ssd_scan_decoder -- self-checking bench for ssd_scan_decoder
// (STABLE_CYCLES=4, TIMEOUT_CYCLES=100). Table-driven frame vectors plus
// hand-written sequences for dwell, illegal select, reset and timeout.
module tb_ssd_scan_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  ssdAnode, ssdCathode;
  logic [19:0] digits;
  logic [3:0]  dp;
  logic        frame_valid, sym_err, anode_err, timeout;

  localparam logic [19:0] BLANK4 = {4{5'd30}};

  int checks = 0;
  int passes = 0;
  int cycle = 0;
  int fvCount, symCount, aerrCount, fvCycle;
  logic [19:0] lastDigits;
  logic [3:0]  lastDp;
  logic        curTimeout = 1'b0;
  logic        lastTimeout = 1'b0;

  typedef struct {
    string       name;
    logic [31:0] cats;
    logic [19:0] expDigits;
    int          expSym;
  } vec_t;

  vec_t vecs[7];

  ssd_scan_decoder #(
    .STABLE_CYCLES  (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ssdAnode    (ssdAnode),
    .ssdCathode  (ssdCathode),
    .digits      (digits),
    .dp          (dp),
    .frame_valid (frame_valid),
    .sym_err     (sym_err),
    .anode_err   (anode_err),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  // Hard stop so the run can never hang
  initial begin
    #300000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected)
      passes++;
    else
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
  endtask

  // Drive inputs for n cycles, sampling outputs at each falling edge
  task automatic applyStimulus(input logic [7:0] an, input logic [7:0] cat, input int n);
    for (int i = 0; i < n; i++) begin
      ssdAnode   = an;
      ssdCathode = cat;
      @(negedge clk);
      cycle++;
      lastTimeout = curTimeout;
      curTimeout  = timeout;
      if (frame_valid) begin
        fvCount++;
        fvCycle    = cycle;
        lastDigits = digits;
        lastDp     = dp;
      end
      if (sym_err)   symCount++;
      if (anode_err) aerrCount++;
    end
  endtask

  task automatic clearCounts();
    fvCount = 0;
    symCount = 0;
    aerrCount = 0;
    lastDigits = '0;
    lastDp = '0;
  endtask

  // One full scan, digit 0 first, then a blank flush
  task automatic scanFrame(input logic [31:0] cats, input int hold);
    logic [7:0] an;
    for (int d = 0; d < 4; d++) begin
      an = ~(8'h01 << d);
      applyStimulus(an, cats[8*d +: 8], hold);
    end
    applyStimulus(8'hFF, 8'hFF, 4);
  endtask

  function automatic logic [3:0] expectedDp(input logic [31:0] cats);
    logic [3:0] r;
    r = 4'h0;
`ifdef SSD_DP_CAPTURE_EN
    for (int d = 0; d < 4; d++) r[d] = ~cats[8*d+7];
`endif
    return r;
  endfunction

  initial begin
    vecs[0] = '{"ILdE",  {8'hCF, 8'hA1, 8'hC7, 8'h86}, {5'd23, 5'd28, 5'd24, 5'd27}, 0};
    vecs[1] = '{"0123",  {8'hC0, 8'hF9, 8'hA4, 8'hB0}, {5'd0,  5'd1,  5'd2,  5'd3},  0};
    vecs[2] = '{"4567",  {8'h99, 8'h92, 8'h82, 8'hF8}, {5'd4,  5'd5,  5'd6,  5'd7},  0};
    vecs[3] = '{"89FA",  {8'h80, 8'h90, 8'h8E, 8'h88}, {5'd8,  5'd9,  5'd21, 5'd22}, 0};
    vecs[4] = '{"b5_08", {8'hFF, 8'h92, 8'hC0, 8'h80}, {5'd30, 5'd5,  5'd0,  5'd8},  0};
    vecs[5] = '{"bX_08", {8'hFF, 8'hAA, 8'hC0, 8'h80}, {5'd30, 5'd31, 5'd0,  5'd8},  1};
    vecs[6] = '{"dp321", {8'h30, 8'h24, 8'h79, 8'h40}, {5'd3,  5'd2,  5'd1,  5'd0},  0};

    // Reset state
    reset = 1'b0;
    ssdAnode = 8'hFF;
    ssdCathode = 8'hFF;
    clearCounts();
    repeat (3) @(negedge clk);
    checkOutput("rst_digits", digits, BLANK4);
    checkOutput("rst_dp", dp, 4'h0);
    checkOutput("rst_frame_valid", frame_valid, 1'b0);
    checkOutput("rst_sym_err", sym_err, 1'b0);
    checkOutput("rst_anode_err", anode_err, 1'b0);
    checkOutput("rst_timeout", timeout, 1'b0);
    reset = 1'b1;
    applyStimulus(8'hFF, 8'hFF, 3);

    // Table-driven full frames
    for (int v = 0; v < 7; v++) begin
      clearCounts();
      scanFrame(vecs[v].cats, 8);
      checkOutput({vecs[v].name, "_frames"}, fvCount, 1);
      checkOutput({vecs[v].name, "_digits"}, lastDigits, vecs[v].expDigits);
      checkOutput({vecs[v].name, "_dp"}, lastDp, expectedDp(vecs[v].cats));
      checkOutput({vecs[v].name, "_sym_err"}, symCount, vecs[v].expSym);
      checkOutput({vecs[v].name, "_anode_err"}, aerrCount, 0);
    end

    // Short dwell (3 samples) must not capture; 4 samples must
    clearCounts();
    applyStimulus(8'hFE, 8'hB0, 3);
    applyStimulus(8'hFD, 8'hF9, 8);
    applyStimulus(8'hFB, 8'hA4, 8);
    applyStimulus(8'hF7, 8'hC0, 8);
    applyStimulus(8'hFF, 8'hFF, 4);
    checkOutput("dwell3_no_frame", fvCount, 0);
    applyStimulus(8'hFE, 8'hB0, 4);
    applyStimulus(8'hFF, 8'hFF, 4);
    checkOutput("dwell4_frames", fvCount, 1);
    checkOutput("dwell4_digits", lastDigits, {5'd0, 5'd2, 5'd1, 5'd3});

    // Two digits low mid-frame: errors each cycle, mask kept, no capture
    clearCounts();
    applyStimulus(8'hFE, 8'hC0, 8);
    applyStimulus(8'hFD, 8'hF9, 8);
    applyStimulus(8'hFB, 8'hA4, 8);
    applyStimulus(8'hFC, 8'hB0, 10);
    applyStimulus(8'hF7, 8'hB0, 8);
    applyStimulus(8'hFF, 8'hFF, 4);
    checkOutput("multi_low_anode_err", aerrCount, 10);
    checkOutput("multi_low_frames", fvCount, 1);
    checkOutput("multi_low_digits", lastDigits, {5'd3, 5'd2, 5'd1, 5'd0});

    // Low bit in [7:4] is an error
    clearCounts();
    applyStimulus(8'h7E, 8'hC0, 5);
    applyStimulus(8'hFF, 8'hFF, 4);
    checkOutput("upper_low_anode_err", aerrCount, 5);
    checkOutput("upper_low_frames", fvCount, 0);

    // Reset after three captures discards the partial frame
    clearCounts();
    applyStimulus(8'hFE, 8'hC0, 8);
    applyStimulus(8'hFD, 8'hF9, 8);
    applyStimulus(8'hFB, 8'hA4, 8);
    reset = 1'b0;
    applyStimulus(8'hFF, 8'hFF, 2);
    checkOutput("mid_rst_digits", digits, BLANK4);
    reset = 1'b1;
    applyStimulus(8'hFF, 8'hFF, 2);
    applyStimulus(8'hFD, 8'hF9, 8);
    applyStimulus(8'hFB, 8'hA4, 8);
    applyStimulus(8'hF7, 8'hC0, 8);
    applyStimulus(8'hFF, 8'hFF, 4);
    checkOutput("post_rst_3cap_frames", fvCount, 0);
    applyStimulus(8'hFE, 8'hB0, 8);
    applyStimulus(8'hFF, 8'hFF, 4);
    checkOutput("post_rst_4cap_frames", fvCount, 1);
    checkOutput("post_rst_digits", lastDigits, {5'd0, 5'd2, 5'd1, 5'd3});

    // Timeout rises 100 cycles after the last capture
    clearCounts();
    scanFrame(vecs[0].cats, 8);
    checkOutput("tmo_frames", fvCount, 1);
    for (int w = 0; w < 300 && !curTimeout; w++)
      applyStimulus(8'hFF, 8'hFF, 1);
    checkOutput("tmo_rise_seen", curTimeout, 1'b1);
    checkOutput("tmo_rise_delay", cycle - fvCycle, 100);

    // Next capture drops timeout one cycle later (sym_err marks that cycle)
    for (int w = 0; w < 20 && symCount == 0; w++)
      applyStimulus(8'hFE, 8'hAA, 1);
    checkOutput("tmo_capture_seen", symCount, 1);
    checkOutput("tmo_high_at_capture", lastTimeout, 1'b1);
    checkOutput("tmo_low_after_capture", curTimeout, 1'b0);
    applyStimulus(8'hFF, 8'hFF, 4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
